// File: rtl/present_dec.sv
// present_dec: iterative PRESENT-80 decryption core, one round per clock.
// Accepts a 64-bit ciphertext and an 80-bit key. Replays the forward key
// schedule to reach the last round key, then unwinds 31 rounds using the
// inverse key schedule.
//
// Optional feature: define PRESENT_DEC_KEY_CACHE_EN to remember the last
// expanded key. A request that reuses that key then skips key expansion.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; inputs captured on the accepting edge
// KEYEXP | forward key schedule, rc = 1..31, ends holding K32
// DEC    | inverse rounds r = 31..1, key walked back to K1
// DONE   | final whitening with K1; done pulse registered on exit
//
// The ports use MSB-first [0:N] numbering. Internally the registers are
// [N:0] with the MSB at the top, so port bit 0 maps to internal bit N.
// That puts the key-schedule fields at k[79:76] and k[19:15].
module present_dec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:63] cipher,
    input  logic [0:79] keys,
    output logic        busy,
    output logic        done,
    output logic [0:63] plain
);

    typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

    state_t      state;
    logic [63:0] st;
    logic [79:0] k;
    logic [4:0]  rc;
    logic [63:0] plain_q;

`ifdef PRESENT_DEC_KEY_CACHE_EN
    logic [79:0] key_cap;
    logic [79:0] ck_key;
    logic [79:0] ck_last;
    logic        ck_vld;
`endif

    logic [79:0] k_fwd;
    logic [79:0] k_xs;
    logic [79:0] k_inv;
    logic [63:0] st_dec;
    logic [63:0] dec_x;
    logic [63:0] dec_p;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    // The forward permutation sends bit i to 16*i mod 63 (bit 63 stays in
    // place). Its inverse therefore gathers each output bit from there.
    function automatic logic [63:0] inv_player(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[i] = x[(16 * i) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

    // Next-key logic for both schedule directions, and one inverse round.
    always_comb begin
        k_fwd          = {k[18:0], k[79:19]};
        k_fwd[79:76]   = sbox(k_fwd[79:76]);
        k_fwd[19:15]   = k_fwd[19:15] ^ rc;

        k_xs           = k;
        k_xs[19:15]    = k[19:15] ^ rc;
        k_xs[79:76]    = inv_sbox(k_xs[79:76]);
        k_inv          = {k_xs[60:0], k_xs[79:61]};

        dec_x          = st ^ k[79:16];
        dec_p          = inv_player(dec_x);
        st_dec         = '0;
        for (int j = 0; j < 16; j++) begin
            st_dec[4*j +: 4] = inv_sbox(dec_p[4*j +: 4]);
        end
    end

    // Sequencing FSM with registered busy/done/plain outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            st      <= '0;
            k       <= '0;
            rc      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            plain_q <= '0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
            key_cap <= '0;
            ck_key  <= '0;
            ck_last <= '0;
            ck_vld  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle is already IDLE. A start request in that
                    // cycle is held off, so the earliest accept is the
                    // following cycle.
                    if (start && !done) begin
                        st   <= cipher;
                        busy <= 1'b1;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                        if (ck_vld && (keys == ck_key)) begin
                            k     <= ck_last;
                            rc    <= 5'd31;
                            state <= DEC;
                        end else begin
                            k       <= keys;
                            key_cap <= keys;
                            rc      <= 5'd1;
                            state   <= KEYEXP;
                        end
`else
                        k     <= keys;
                        rc    <= 5'd1;
                        state <= KEYEXP;
`endif
                    end
                end
                KEYEXP: begin
                    k <= k_fwd;
                    if (rc == 5'd31) begin
                        state <= DEC;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                        ck_key  <= key_cap;
                        ck_last <= k_fwd;
                        ck_vld  <= 1'b1;
`endif
                    end else begin
                        rc <= rc + 5'd1;
                    end
                end
                DEC: begin
                    st <= st_dec;
                    k  <= k_inv;
                    if (rc == 5'd1) begin
                        state <= DONE;
                    end else begin
                        rc <= rc - 5'd1;
                    end
                end
                DONE: begin
                    plain_q <= st ^ k[79:16];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign plain = plain_q;

endmodule

// File: tb/tb_present_dec.sv
// Scoreboard bench for present_dec. The stimulus pushes the expected
// plaintext and latency when it issues a request. A monitor pops and
// compares them whenever done is seen. Random vectors are produced by a
// forward PRESENT-80 encryption model.
module tb_present_dec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [0:63] cipher = '0;
    logic [0:79] keys = '0;
    logic        busy;
    logic        done;
    logic [0:63] plain;

    present_dec dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cipher (cipher),
        .keys   (keys),
        .busy   (busy),
        .done   (done),
        .plain  (plain)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] pt;
        int          acc;
        int          lat;
    } exp_t;

    exp_t scb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [79:0] m_key = '0;
    logic        m_vld = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] sb4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] p;
        logic [79:0] kk;
        s  = pt;
        kk = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kk[79:16];
            for (int j = 0; j < 16; j++) s[4*j +: 4] = sb4(s[4*j +: 4]);
            p = '0;
            for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16 * i) % 63] = s[i];
            s  = p;
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = sb4(kk[79:76]);
            kk[19:15] = kk[19:15] ^ 5'(r);
        end
        return s ^ kk[79:16];
    endfunction

    // Monitor: each done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            check("busy_at_done", {63'd0, busy}, 64'd0);
            if (scb.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                e = scb.pop_front();
                check("plain", plain, e.pt);
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    // Issue one request, with start held for 'hold' cycles (0 = one cycle).
    task automatic run(input logic [63:0] ct, input logic [79:0] key,
                       input logic [63:0] pt, input int hold);
        int lat;
        int n;
        int low;
        wait_idle();
        cipher = ct;
        keys   = key;
        start  = 1'b1;
        lat    = 63;
`ifdef PRESENT_DEC_KEY_CACHE_EN
        if (m_vld && key == m_key) begin
            lat = 32;
        end else begin
            m_key = key;
            m_vld = 1'b1;
        end
`endif
        scb.push_back('{pt, cyc + 1, lat});
        @(negedge clk);
        if (hold == 0) start = 1'b0;
        n   = 1;
        low = 0;
        while (!done && n < 200) begin
            if (!busy) low++;
            if (n == hold) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", {63'd0, done}, 64'd1);
        check("busy_during_run", 64'(low), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rpt;
        logic [79:0] rkey;

        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_plain", plain, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(64'h5579C1387B228445, 80'h0, 64'h0, 0);
        run(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, 0);
        run(64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, 50);
        run(64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}}, 0);

        // Abort mid-run with reset; no done may follow.
        wait_idle();
        cipher = 64'h5579C1387B228445;
        keys   = '0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        m_vld = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_plain", plain, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        check("abort_idle_busy", {63'd0, busy}, 64'd0);
        check("abort_plain_hold", plain, 64'd0);

        run(64'h5579C1387B228445, 80'h0, 64'h0, 0);

`ifdef PRESENT_DEC_KEY_CACHE_EN
        run(64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, 0);
        run(64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, 0);
        run(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, 0);
`endif

        for (int t = 0; t < 600; t++) begin
            rpt  = {$urandom, $urandom};
            rkey = {$urandom, $urandom, 16'($urandom)};
            run(enc(rpt, rkey), rkey, rpt, 0);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drain", 64'(scb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
